// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file writeback port.
//   XLEN       : data width of a register
//   REG_W      : register index width
//   NREGS      : number of architectural registers
//   wb_entry_t : queued long-latency result (destination + data)
package wb_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned NREGS = 32;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic [XLEN-1:0]  data;
  } wb_entry_t;

  // One-hot register mask for a destination index.
  function automatic logic [NREGS-1:0] reg_onehot(input logic [REG_W-1:0] r);
    reg_onehot = NREGS'(1) << r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO of long-latency writeback entries.
// Ports:
//   clk, reset        : clock, synchronous active-high reset (flushes all entries)
//   push, push_entry  : enqueue request and payload (ignored when full)
//   pop               : dequeue head (ignored when empty)
//   head              : current head entry
//   full, empty       : occupancy flags
//   ent_vld, ent_rd   : per-slot valid bit and destination, for the pending mask
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  wb_entry_t                   push_entry,
  input  logic                        pop,
  output wb_entry_t                   head,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0]            ent_vld,
  output logic [DEPTH-1:0][REG_W-1:0] ent_rd
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_n;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  // Occupancy is tracked per slot so the pending mask needs no pointer math.
  assign full  = &vld;
  assign empty = ~|vld;

  always_comb begin
    push_ok = push && !full;
    pop_ok  = pop && !empty;
    vld_n   = vld;
    if (pop_ok)  vld_n[rd_ptr] = 1'b0;
    if (push_ok) vld_n[wr_ptr] = 1'b1;
  end

  // Pointers and valid bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      vld    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      vld <= vld_n;
    end
  end

  // Payload storage; contents are meaningless unless the slot is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_entry;
  end

  assign head    = mem[rd_ptr];
  assign ent_vld = vld;

  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    assign ent_rd[g] = mem[g].rd;
  end

endmodule

// File: rtl/wb_write_port.sv
// Register-file write port arbiter: merges in-order pipeline writeback with a
// buffered long-latency result stream, one registered write per cycle, and
// raises wb_stall when a queued result has waited too long.
// Optional feature: define WB_BYPASS_EN to add write-first read forwarding.
// Ports:
//   clk, reset                 : clock, synchronous active-high reset
//   wb_valid, wb_rd, wb_data   : pipeline writeback (always accepted)
//   ll_valid, ll_ready, ll_rd, ll_data : long-latency result handshake
//   wb_stall                   : registered; pipeline must hold off while high
//   pending                    : mask of registers targeted by queued entries
//   RegWrite, A3, WD3          : registered regfile write port
//   fwd_a1/a2, rf_rd1/rd2, fwd_rd1/rd2 : bypass read path (WB_BYPASS_EN only)
module wb_write_port
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wb_valid,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             ll_valid,
  output logic             ll_ready,
  input  logic [REG_W-1:0] ll_rd,
  input  logic [XLEN-1:0]  ll_data,
  output logic             wb_stall,
  output logic [NREGS-1:0] pending,
  output logic             RegWrite,
  output logic [REG_W-1:0] A3,
  output logic [XLEN-1:0]  WD3
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_W-1:0] fwd_a1,
  input  logic [REG_W-1:0] fwd_a2,
  input  logic [XLEN-1:0]  rf_rd1,
  input  logic [XLEN-1:0]  rf_rd2,
  output logic [XLEN-1:0]  fwd_rd1,
  output logic [XLEN-1:0]  fwd_rd2
`endif
);

  localparam int unsigned CNT_W = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STARVE_MAX - 1);

  wb_entry_t                   head;
  wb_entry_t                   push_entry;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [DEPTH-1:0]            ent_vld;
  logic [DEPTH-1:0][REG_W-1:0] ent_rd;
  logic                        ll_push;
  logic                        issue_wb;
  logic                        issue_ll;
  logic                        reg_write_n;
  logic [REG_W-1:0]            a3_n;
  logic [XLEN-1:0]             wd3_n;
  logic [CNT_W-1:0]            starve_cnt;
  logic [CNT_W-1:0]            cnt_n;
  logic                        stall_n;

  assign push_entry = '{rd: ll_rd, data: ll_data};

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (ll_push),
    .push_entry (push_entry),
    .pop        (issue_ll),
    .head       (head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .ent_vld    (ent_vld),
    .ent_rd     (ent_rd)
  );

  // Arbitration, handshake and next-state for output regs and starvation logic.
  always_comb begin
    issue_wb    = wb_valid && (wb_rd != '0);
    issue_ll    = !issue_wb && !fifo_empty;
    ll_ready    = !fifo_full && !reset;
    // x0 results complete the handshake but are never queued.
    ll_push     = ll_valid && ll_ready && (ll_rd != '0);
    reg_write_n = 1'b0;
    a3_n        = A3;
    wd3_n       = WD3;
    cnt_n       = starve_cnt;
    stall_n     = wb_stall;

    if (issue_wb) begin
      reg_write_n = 1'b1;
      a3_n        = wb_rd;
      wd3_n       = wb_data;
    end else if (issue_ll) begin
      reg_write_n = 1'b1;
      a3_n        = head.rd;
      wd3_n       = head.data;
    end

    // Counter saturates so a misbehaving pipeline cannot wrap it back to zero.
    if (fifo_empty || issue_ll) begin
      cnt_n = '0;
    end else if (starve_cnt != CNT_LAST) begin
      cnt_n = starve_cnt + CNT_W'(1);
    end

    if (issue_ll) begin
      stall_n = 1'b0;
    end else if (!fifo_empty && (starve_cnt == CNT_LAST)) begin
      stall_n = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      RegWrite   <= 1'b0;
      A3         <= '0;
      WD3        <= '0;
      wb_stall   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      RegWrite   <= reg_write_n;
      A3         <= a3_n;
      WD3        <= wd3_n;
      wb_stall   <= stall_n;
      starve_cnt <= cnt_n;
    end
  end

  // Entries stay in the mask through the cycle they are popped.
  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_vld[i]) pending = pending | reg_onehot(ent_rd[i]);
    end
  end

`ifdef WB_BYPASS_EN
  // Write-first reads: a read of the register being committed sees the new value.
  assign fwd_rd1 = (RegWrite && (A3 != '0) && (A3 == fwd_a1)) ? WD3 : rf_rd1;
  assign fwd_rd2 = (RegWrite && (A3 != '0) && (A3 == fwd_a2)) ? WD3 : rf_rd2;
`endif

  a_no_wb_during_stall: assert property (@(posedge clk) disable iff (reset)
    !(wb_valid && wb_stall));

endmodule

// File: tb/tb_wb_write_port.sv
// Directed bench for wb_write_port: reset, pipeline path, long-latency path,
// FIFO full back-pressure, starvation stall and (optionally) the bypass path.
module tb_wb_write_port;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ll_valid;
  logic        ll_ready;
  logic [4:0]  ll_rd;
  logic [31:0] ll_data;
  logic        wb_stall;
  logic [31:0] pending;
  logic        RegWrite;
  logic [4:0]  A3;
  logic [31:0] WD3;
`ifdef WB_BYPASS_EN
  logic [4:0]  fwd_a1;
  logic [4:0]  fwd_a2;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic [31:0] fwd_rd1;
  logic [31:0] fwd_rd2;
`endif

  int total = 0;
  int bad   = 0;

  wb_write_port dut (
    .clk      (clk),
    .reset    (reset),
    .wb_valid (wb_valid),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .ll_valid (ll_valid),
    .ll_ready (ll_ready),
    .ll_rd    (ll_rd),
    .ll_data  (ll_data),
    .wb_stall (wb_stall),
    .pending  (pending),
    .RegWrite (RegWrite),
    .A3       (A3),
    .WD3      (WD3)
`ifdef WB_BYPASS_EN
    ,
    .fwd_a1   (fwd_a1),
    .fwd_a2   (fwd_a2),
    .rf_rd1   (rf_rd1),
    .rf_rd2   (rf_rd2),
    .fwd_rd1  (fwd_rd1),
    .fwd_rd2  (fwd_rd2)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset    = 1'b1;
    wb_valid = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    ll_valid = 1'b0;
    ll_rd    = '0;
    ll_data  = '0;
`ifdef WB_BYPASS_EN
    fwd_a1 = '0;
    fwd_a2 = '0;
    rf_rd1 = '0;
    rf_rd2 = '0;
`endif

    // Power-on reset, two cycles.
    #1;
    check("rst_ll_ready_t0", 32'(ll_ready), 32'd0);
    step();
    step();
    check("rst_regwrite", 32'(RegWrite), 32'd0);
    check("rst_a3", 32'(A3), 32'd0);
    check("rst_wd3", WD3, 32'd0);
    check("rst_stall", 32'(wb_stall), 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_ll_ready", 32'(ll_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("post_rst_ll_ready", 32'(ll_ready), 32'd1);
    step();

    // Pipeline write: visible exactly one cycle.
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEADBEEF;
    step();
    check("wb_regwrite", 32'(RegWrite), 32'd1);
    check("wb_a3", 32'(A3), 32'd5);
    check("wb_wd3", WD3, 32'hDEADBEEF);
    wb_valid = 1'b0;
    step();
    check("wb_regwrite_off", 32'(RegWrite), 32'd0);
    check("wb_a3_hold", 32'(A3), 32'd5);
    check("wb_wd3_hold", WD3, 32'hDEADBEEF);

    // x0 pipeline write is dropped.
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'h12345678;
    step();
    check("wb_x0_dropped", 32'(RegWrite), 32'd0);
    wb_valid = 1'b0;

`ifdef WB_BYPASS_EN
    // Bypass: commit-cycle read of the written register returns the new value.
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h55;
    step();
    wb_valid = 1'b0;
    fwd_a1 = 5'd9; rf_rd1 = 32'h0;
    fwd_a2 = 5'd0; rf_rd2 = 32'h1234;
    #1;
    check("fwd_rd1_bypass", fwd_rd1, 32'h55);
    check("fwd_rd2_pass", fwd_rd2, 32'h1234);
    step();
    check("fwd_rd1_idle", fwd_rd1, 32'h0);
`endif

    // Single long-latency push with pipeline idle.
    ll_valid = 1'b1; ll_rd = 5'd7; ll_data = 32'h11;
    #1;
    check("ll_ready_idle", 32'(ll_ready), 32'd1);
    step();
    ll_valid = 1'b0;
    check("ll_pending_set", pending, 32'h0000_0080);
    check("ll_no_write_yet", 32'(RegWrite), 32'd0);
    step();
    check("ll_regwrite", 32'(RegWrite), 32'd1);
    check("ll_a3", 32'(A3), 32'd7);
    check("ll_wd3", WD3, 32'h11);
    check("ll_pending_clr", pending, 32'd0);
    step();
    check("ll_regwrite_off", 32'(RegWrite), 32'd0);

    // Fill the FIFO while the pipeline owns the port.
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1; wb_rd = 5'(i + 1); wb_data = 32'h100 + 32'(i);
      ll_valid = 1'b1; ll_rd = 5'(10 + i); ll_data = 32'hA0 + 32'(i);
      step();
      check("fill_wb_a3", 32'(A3), 32'(i + 1));
    end
    check("full_ll_ready", 32'(ll_ready), 32'd0);
    check("full_pending", pending, 32'h0000_3C00);
    check("full_wd3", WD3, 32'h103);
    // Fifth entry held while full.
    wb_rd = 5'd3; wb_data = 32'h1FF;
    ll_rd = 5'd14; ll_data = 32'hA4;
    step();
    check("held_pending", pending, 32'h0000_3C00);
    check("held_ll_ready", 32'(ll_ready), 32'd0);
    // Pipeline idle: head pops; full during that cycle so the fifth is not taken yet.
    wb_valid = 1'b0;
    step();
    check("drain0_a3", 32'(A3), 32'd10);
    check("drain0_wd3", WD3, 32'hA0);
    check("drain0_ll_ready", 32'(ll_ready), 32'd1);
    check("drain0_pending", pending, 32'h0000_3800);
    step();
    ll_valid = 1'b0;
    check("drain1_a3", 32'(A3), 32'd11);
    check("drain1_pending", pending, 32'h0000_7000);
    for (int k = 12; k <= 14; k++) begin
      step();
      check("drain_rw", 32'(RegWrite), 32'd1);
      check("drain_a3", 32'(A3), 32'(k));
      check("drain_wd3", WD3, 32'hA0 + 32'(k - 10));
    end
    step();
    check("drain_done_rw", 32'(RegWrite), 32'd0);
    check("drain_done_pending", pending, 32'd0);
    check("drain_no_stall", 32'(wb_stall), 32'd0);

    // Starvation: continuous pipeline traffic, one queued entry.
    wb_valid = 1'b1; wb_rd = 5'd20; wb_data = 32'h200;
    ll_valid = 1'b1; ll_rd = 5'd8; ll_data = 32'h88;
    step();
    ll_valid = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      wb_data = 32'h200 + 32'(k);
      step();
    end
    check("starve_a3_wb", 32'(A3), 32'd20);
    check("starve_no_stall_yet", 32'(wb_stall), 32'd0);
    check("starve_pending", pending, 32'h0000_0100);
    wb_data = 32'h208;
    step();
    check("starve_stall_set", 32'(wb_stall), 32'd1);
    check("starve_last_wb", WD3, 32'h208);
    wb_valid = 1'b0;
    step();
    check("starve_issue_a3", 32'(A3), 32'd8);
    check("starve_issue_wd3", WD3, 32'h88);
    check("starve_stall_clr", 32'(wb_stall), 32'd0);
    check("starve_pending_clr", pending, 32'd0);

    // Reset mid-traffic flushes queued entries.
    wb_valid = 1'b1; wb_rd = 5'd17; wb_data = 32'h300;
    ll_valid = 1'b1; ll_rd = 5'd15; ll_data = 32'hB0;
    step();
    ll_rd = 5'd16; ll_data = 32'hB1;
    step();
    ll_valid = 1'b0;
    check("pre_rst_pending", pending, 32'h0001_8000);
    reset = 1'b1; wb_data = 32'h999;
    #1;
    check("mid_rst_ll_ready0", 32'(ll_ready), 32'd0);
    step();
    check("mid_rst_rw", 32'(RegWrite), 32'd0);
    check("mid_rst_a3", 32'(A3), 32'd0);
    check("mid_rst_pending", pending, 32'd0);
    step();
    check("mid_rst_ll_ready1", 32'(ll_ready), 32'd0);
    check("mid_rst_wd3", WD3, 32'd0);
    reset = 1'b0; wb_valid = 1'b0;
    #1;
    check("mid_rst_ll_ready_rel", 32'(ll_ready), 32'd1);
    step();
    check("mid_rst_no_drain", 32'(RegWrite), 32'd0);
    check("mid_rst_pending_rel", pending, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
